// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU
// into HI/LO over DATA+2 edges, plus MTHI/MTLO writes while idle.
// Ports: clk, rst (async high); op_a/op_b forwarded rs/rt operands;
//        start + op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) launch request;
//        mthi/mtlo write op_a into HI/LO when idle;
//        hi/lo architectural registers; busy while computing;
//        done one-cycle pulse when HI/LO take a mult/div result.
module mdu_iterative #(
    parameter int DATA = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DATA-1:0] op_a,
    input  logic [DATA-1:0] op_b,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            mthi,
    input  logic            mtlo,
    output logic [DATA-1:0] hi,
    output logic [DATA-1:0] lo,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(DATA);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [DATA-1:0]     a_q, a_d;
    logic [DATA-1:0]     b_q, b_d;
    logic [2*DATA-1:0]   acc_q, acc_d;
    logic [DATA-1:0]     hi_q, hi_d;
    logic [DATA-1:0]     lo_q, lo_d;
    logic                done_q, done_d;

    logic                is_signed;
    logic [DATA-1:0]     a_abs, b_abs;
    logic [DATA:0]       mul_sum;
    logic [DATA:0]       rem_sh;
    logic [DATA:0]       rem_diff;
    logic [2*DATA-1:0]   prod_fix;
    logic [DATA-1:0]     quo_fix, rem_fix;

    assign is_signed = ~op[0];
    assign a_abs = (is_signed && op_a[DATA-1]) ? -op_a : op_a;
    assign b_abs = (is_signed && op_b[DATA-1]) ? -op_b : op_b;

    // Shift-add: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc_q[2*DATA-1:DATA]}
                   + {1'b0, (acc_q[0] ? a_q : {DATA{1'b0}})};

    // Restoring divide: acc holds {remainder, dividend/quotient bits}.
    assign rem_sh   = acc_q[2*DATA-1:DATA-1];
    assign rem_diff = rem_sh - {1'b0, b_q};

    // Sign fix-up; remainder follows the dividend (truncating division).
    assign prod_fix = (~op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    assign rem_fix  = (~op_q[0] && sign_a_q) ? -acc_q[2*DATA-1:DATA]
                                             : acc_q[2*DATA-1:DATA];
    // Divide by zero reports an all-ones quotient regardless of signs.
    assign quo_fix  = (b_q == '0) ? {DATA{1'b1}} :
                      (~op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q[DATA-1:0]
                                                          : acc_q[DATA-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: if (cnt_q == CW'(DATA-1)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mthi) hi_d = op_a;
                if (mtlo) lo_d = op_a;
                if (start) begin
                    op_d     = op;
                    sign_a_d = is_signed & op_a[DATA-1];
                    sign_b_d = is_signed & op_b[DATA-1];
                    a_d      = a_abs;
                    b_d      = b_abs;
                    cnt_d    = '0;
                    acc_d    = op[1] ? {{DATA{1'b0}}, a_abs}
                                     : {{DATA{1'b0}}, b_abs};
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (!op_q[1]) begin
                    acc_d = {mul_sum, acc_q[DATA-1:1]};
                end else if (!rem_diff[DATA]) begin
                    acc_d = {rem_diff[DATA-1:0], acc_q[DATA-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[DATA-1:0], acc_q[DATA-2:0], 1'b0};
                end
            end
            FIX: begin
                done_d = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*DATA-1:DATA];
                    lo_d = prod_fix[DATA-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table plus
// hand-written sequences for busy-time ignores, MT writes and reset abort.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    mdu_iterative #(.DATA(32)) dut (
        .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b),
        .start(start), .op(op), .mthi(mthi), .mtlo(mtlo),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Launch at a negedge; returns edges until done seen and busy count.
    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int bcnt);
        op = o; op_a = a; op_b = b; start = 1'b1;
        lat = 0; bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, bcnt, pulses, both;

    initial begin
        vecs[0] = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_m7x3", 2'b00, 32'hFFFFFFF9, 32'd3,
                    32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{"mult_min2", 2'b00, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h00000000};
        vecs[3] = '{"multu_sh", 2'b01, 32'h12345678, 32'h10,
                    32'h00000001, 32'h23456780};
        vecs[4] = '{"div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{"div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD};
        vecs[6] = '{"divu_100d7", 2'b11, 32'd100, 32'd7,
                    32'd2, 32'd14};
        vecs[7] = '{"div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
                    32'h00000000, 32'h80000000};
        vecs[8] = '{"divu_by0", 2'b11, 32'h1234, 32'h0,
                    32'h00001234, 32'hFFFFFFFF};

        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            chk({vecs[i].name, "_lat"}, lat, 34);
            chk({vecs[i].name, "_busy"}, bcnt, 33);
            chk({vecs[i].name, "_bsy_dn"}, {31'b0, busy}, 32'h0);
            @(negedge clk);
            chk({vecs[i].name, "_dn_drop"}, {31'b0, done}, 32'h0);
        end

        // start and mthi mid-CALC are ignored; single done pulse
        op = 2'b11; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        op = 2'b01; op_a = 32'hDEAD; op_b = 32'h3; start = 1'b1; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        pulses = 0; both = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) pulses++;
            if (done && busy) both++;
            if (c == 27) begin
                chk("ign_hi", hi, 32'd2);
                chk("ign_lo", lo, 32'd14);
            end
            @(negedge clk);
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_both", both, 0);
        chk("ign_hi_end", hi, 32'd2);

        // mtlo while idle
        op_a = 32'hBEEF; mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'hBEEF);
        chk("mtlo_hi", hi, 32'd2);

        // mthi with start: visible immediately, then overwritten
        op = 2'b01; op_a = 32'h5; op_b = 32'h6; start = 1'b1; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("mtst_hi_now", hi, 32'h5);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mtst_lat", lat, 34);
        chk("mtst_hi", hi, 32'h0);
        chk("mtst_lo", lo, 32'd30);

        // async reset mid-CALC aborts
        op = 2'b01; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        chk("abort_quiet", pulses, 0);
        launch(2'b11, 32'd100, 32'd7, lat, bcnt);
        chk("fresh_lat", lat, 34);
        chk("fresh_hi", hi, 32'd2);
        chk("fresh_lo", lo, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
